// File: rtl/mannix_rd_arb_pkg.sv
// Shared constants and types for the Mannix five-client SRAM read arbiter.
package mannix_rd_arb_pkg;

    localparam int NUM_CLIENTS  = 5;
    localparam int CLIENT_IDX_W = $clog2(NUM_CLIENTS);
    localparam int STARVE_LIMIT = 15;
    localparam int STARVE_W     = 4;

    typedef logic [CLIENT_IDX_W-1:0] client_idx_t;

    typedef enum logic [CLIENT_IDX_W-1:0] {
        CL_FCC     = 3'd0,
        CL_ACTIVE  = 3'd1,
        CL_CNN_PIC = 3'd2,
        CL_CNN_WGT = 3'd3,
        CL_POOL    = 3'd4
    } client_e;

endpackage

// File: rtl/mannix_rd_arbiter_if.sv
// Client-side and memory-side read handshake bundle for mannix_rd_arbiter.
interface mannix_rd_arbiter_if
    import mannix_rd_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [NUM_CLIENTS-1:0]        client_req;
    logic [NUM_CLIENTS*ADDR_W-1:0] client_addr;
    logic [NUM_CLIENTS-1:0]        client_priority;
    logic [NUM_CLIENTS-1:0]        client_gnt;
    logic [NUM_CLIENTS-1:0]        client_rvalid;
    logic [DATA_W-1:0]             client_rdata;
    logic                          mem_req;
    logic [ADDR_W-1:0]             mem_addr;
    logic                          mem_ready;
    logic                          mem_rvalid;
    logic [DATA_W-1:0]             mem_rdata;

    // The arbiter side.
    modport slave (
        input  client_req, client_addr, client_priority, mem_ready, mem_rvalid, mem_rdata,
        output client_gnt, client_rvalid, client_rdata, mem_req, mem_addr
    );

    // The clients and the memory farm, as seen from outside the arbiter.
    modport master (
        output client_req, client_addr, client_priority, mem_ready, mem_rvalid, mem_rdata,
        input  client_gnt, client_rvalid, client_rdata, mem_req, mem_addr
    );
endinterface

// File: rtl/mannix_tag_fifo.sv
// Synchronous FIFO of client indices remembering who owns each outstanding read.
module mannix_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops see pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/mannix_rd_arbiter.sv
// Five-client round-robin read arbiter with priority mask and in-order response tagging.
// Optional starvation guard enabled by defining MANNIX_RD_ARB_STARVE_GUARD_EN.
module mannix_rd_arbiter
    import mannix_rd_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int TAG_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mannix_rd_arbiter_if.slave  bus,
    output logic                err_orphan
);
    logic [NUM_CLIENTS-1:0] hi_req, eligible, gnt;
    logic [NUM_CLIENTS-1:0] starved;
    client_idx_t            rr_ptr_q, rr_ptr_d, winner, head;
    logic                   found, mem_req, accept, pop;
    logic                   fifo_full, fifo_empty;
    logic                   err_orphan_q, err_orphan_d;

`ifdef MANNIX_RD_ARB_STARVE_GUARD_EN
    logic [STARVE_W-1:0] wait_q [NUM_CLIENTS];
    logic [STARVE_W-1:0] wait_d [NUM_CLIENTS];

    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            starved[i] = bus.client_req[i] && (wait_q[i] == STARVE_W'(STARVE_LIMIT));
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            wait_d[i] = wait_q[i];
            if (gnt[i]) wait_d[i] = '0;
            else if (bus.client_req[i] && !starved[i]) wait_d[i] = wait_q[i] + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            wait_q[i] <= !rst_n ? '0 : wait_d[i];
        end
    end
`else
    assign starved = '0;
`endif

    always_comb begin
        hi_req   = bus.client_req & bus.client_priority;
        eligible = (hi_req != '0) ? hi_req : bus.client_req;
        winner   = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!found && eligible[(int'(rr_ptr_q) + i) % NUM_CLIENTS]) begin
                winner = client_idx_t'((int'(rr_ptr_q) + i) % NUM_CLIENTS);
                found  = 1'b1;
            end
        end
        // A starved requester overrides the mask; scanning downward leaves the lowest index.
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (starved[i]) winner = client_idx_t'(i);
        end
    end

    always_comb begin
        mem_req      = found & ~fifo_full;
        accept       = mem_req & bus.mem_ready;
        gnt          = NUM_CLIENTS'(accept) << winner;
        pop          = bus.mem_rvalid & ~fifo_empty;
        rr_ptr_d     = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (winner == client_idx_t'(CL_POOL)) ? '0 : winner + client_idx_t'(1);
        end
        err_orphan_d = err_orphan_q | (bus.mem_rvalid & fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    mannix_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (CLIENT_IDX_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (winner),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    assign bus.mem_req       = mem_req;
    assign bus.mem_addr      = bus.client_addr[winner*ADDR_W +: ADDR_W];
    assign bus.client_gnt    = gnt;
    assign bus.client_rvalid = NUM_CLIENTS'(pop) << head;
    assign bus.client_rdata  = bus.mem_rdata;
    assign err_orphan        = err_orphan_q;
endmodule

// File: tb/tb_mannix_rd_arbiter.sv
// Scoreboard bench for mannix_rd_arbiter: expected grants from fixed tables, responses via queue.
module tb_mannix_rd_arbiter;
    import mannix_rd_arb_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 64;
    localparam int TAG_DEPTH = 4;

    typedef struct {
        logic [NUM_CLIENTS-1:0] onehot;
        logic [DATA_W-1:0]      data;
    } exp_rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic err_orphan;

    int n_checks = 0;
    int n_errors = 0;

    exp_rsp_t          sb[$];
    logic [ADDR_W-1:0] memq[$];
    logic              exp_orphan;

    always #5 clk = ~clk;

    mannix_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mannix_rd_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .TAG_DEPTH (TAG_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .err_orphan (err_orphan)
    );

    function automatic logic [ADDR_W-1:0] addr_of(input int k);
        return 32'h4000_0000 + 32'(k) * 32'h0000_0110;
    endfunction

    function automatic logic [DATA_W-1:0] rdata_of(input logic [ADDR_W-1:0] a);
        return {a ^ 32'hA5A5_5A5A, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check settled outputs mid-cycle, update models, advance.
    task automatic cycle(input string tag, input logic [NUM_CLIENTS-1:0] req,
                         input logic [NUM_CLIENTS-1:0] prio, input logic rdy,
                         input logic rv, input int exp_win, input logic exp_mreq);
        bit had_rsp;
        bus.client_req      = req;
        bus.client_priority = prio;
        bus.mem_ready       = rdy;
        bus.mem_rvalid      = rv;
        bus.mem_rdata       = (rv && memq.size() > 0) ? rdata_of(memq[0]) : 64'hDEAD_BEEF_0BAD_F00D;
        #2;
        check({tag, " mem_req"}, 64'(bus.mem_req), 64'(exp_mreq));
        check({tag, " gnt"}, 64'(bus.client_gnt),
              (exp_mreq && rdy) ? 64'(5'b00001 << exp_win) : 64'd0);
        if (exp_win >= 0) check({tag, " addr"}, 64'(bus.mem_addr), 64'(addr_of(exp_win)));
        had_rsp = (sb.size() > 0);
        if (rv && had_rsp) begin
            exp_rsp_t e;
            e = sb.pop_front();
            check({tag, " rvalid"}, 64'(bus.client_rvalid), 64'(e.onehot));
            check({tag, " rdata"}, bus.client_rdata, e.data);
        end else begin
            check({tag, " rvalid idle"}, 64'(bus.client_rvalid), 64'd0);
        end
        check({tag, " err_orphan"}, 64'(err_orphan), 64'(exp_orphan));
        if (exp_mreq && rdy) begin
            exp_rsp_t n;
            n.onehot = NUM_CLIENTS'(5'b00001 << exp_win);
            n.data   = rdata_of(addr_of(exp_win));
            sb.push_back(n);
        end
        if (bus.mem_req && bus.mem_ready) memq.push_back(bus.mem_addr);
        if (rv && memq.size() > 0) void'(memq.pop_front());
        if (rv && !had_rsp) exp_orphan = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        memq.delete();
        exp_orphan = 1'b0;
        @(posedge clk);
        #1;
        cycle("in_reset", 5'b00000, 5'b00000, 1'b0, 1'b0, -1, 1'b0);
        rst_n = 1'b1;
        cycle("idle", 5'b00000, 5'b00000, 1'b1, 1'b0, -1, 1'b0);
    endtask

    int rr_exp[6]   = '{int'(CL_FCC), int'(CL_ACTIVE), int'(CL_CNN_PIC),
                        int'(CL_CNN_WGT), int'(CL_POOL), int'(CL_FCC)};
    int prio_exp[4] = '{int'(CL_CNN_PIC), int'(CL_POOL), int'(CL_CNN_PIC), int'(CL_POOL)};

    initial begin
        rst_n               = 1'b0;
        bus.client_req      = '0;
        bus.client_priority = '0;
        bus.mem_ready       = 1'b0;
        bus.mem_rvalid      = 1'b0;
        bus.mem_rdata       = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) bus.client_addr[k*ADDR_W +: ADDR_W] = addr_of(k);
        exp_orphan = 1'b0;

        do_reset();

        // Round-robin over all five clients, response one cycle after each grant.
        for (int c = 0; c < 6; c++)
            cycle("rr", 5'b11111, 5'b00000, 1'b1, c > 0, rr_exp[c], 1'b1);
        cycle("rr_drain", 5'b00000, 5'b00000, 1'b1, 1'b1, -1, 1'b0);

        // Priority mask: only cnn_pic and pool may win.
        for (int c = 0; c < 4; c++)
            cycle("prio", 5'b11111, 5'b10100, 1'b1, c > 0, prio_exp[c], 1'b1);
        cycle("prio_drain", 5'b00000, 5'b00000, 1'b1, 1'b1, -1, 1'b0);

        // Fill the tag FIFO, stall at full, free one slot, then grant resumes a cycle later.
        for (int c = 0; c < 4; c++)
            cycle("fill", 5'b11111, 5'b00000, 1'b1, 1'b0, c, 1'b1);
        for (int c = 0; c < 2; c++)
            cycle("full", 5'b11111, 5'b00000, 1'b1, 1'b0, -1, 1'b0);
        cycle("full_pop", 5'b11111, 5'b00000, 1'b1, 1'b1, -1, 1'b0);
        cycle("after_pop", 5'b11111, 5'b00000, 1'b1, 1'b0, int'(CL_POOL), 1'b1);
        for (int c = 0; c < 4; c++)
            cycle("full_drain", 5'b00000, 5'b00000, 1'b1, 1'b1, -1, 1'b0);

        // Backpressure: request and address held while memory is not ready.
        for (int c = 0; c < 2; c++)
            cycle("bp_stall", 5'b01000, 5'b00000, 1'b0, 1'b0, int'(CL_CNN_WGT), 1'b1);
        cycle("bp_go", 5'b01000, 5'b00000, 1'b1, 1'b0, int'(CL_CNN_WGT), 1'b1);
        cycle("bp_drain", 5'b00000, 5'b00000, 1'b1, 1'b1, -1, 1'b0);

        // Orphan response with the FIFO empty; the flag is sticky.
        cycle("orphan", 5'b00000, 5'b00000, 1'b1, 1'b1, -1, 1'b0);
        for (int c = 0; c < 2; c++)
            cycle("orphan_hold", 5'b00000, 5'b00000, 1'b1, 1'b0, -1, 1'b0);

        // A read in flight across reset returns as an orphan.
        do_reset();
        cycle("inflight", 5'b00100, 5'b00000, 1'b1, 1'b0, int'(CL_CNN_PIC), 1'b1);
        do_reset();
        cycle("late_rsp", 5'b00000, 5'b00000, 1'b1, 1'b1, -1, 1'b0);
        cycle("late_hold", 5'b00000, 5'b00000, 1'b1, 1'b0, -1, 1'b0);

`ifdef MANNIX_RD_ARB_STARVE_GUARD_EN
        // Low-priority active engine wins after fifteen waiting cycles.
        do_reset();
        for (int c = 0; c < 15; c++)
            cycle("starve_wait", 5'b00011, 5'b00001, 1'b1, c > 0, int'(CL_FCC), 1'b1);
        cycle("starve_win", 5'b00011, 5'b00001, 1'b1, 1'b1, int'(CL_ACTIVE), 1'b1);
        cycle("starve_after", 5'b00011, 5'b00001, 1'b1, 1'b1, int'(CL_FCC), 1'b1);
        cycle("starve_drain", 5'b00000, 5'b00000, 1'b1, 1'b1, -1, 1'b0);
`endif

        do_reset();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
